// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for the fetch front end
//
// Purpose: constants shared by the fetch queue and the pipeline registers.
// Ports: none (package).
package cpu_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  // Injected into IF/ID by its flush logic; the fetch queue never uses it.
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding fetched {pc, inst} entries
//
// Purpose: DEPTH x WIDTH queue with push, pop, flush and occupancy.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         drop all entries at the edge (overrides push/pop)
//   push, push_data  write at the tail; accepted when not full or popping
//   pop           remove the head; ignored when empty
//   head_data     head entry, 0 when empty
//   count         occupancy
//   full, empty   occupancy flags
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  logic             do_pop;
  logic             do_push;

  assign empty   = (occ == '0);
  assign full    = (occ == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];
  assign count     = occ;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with decoupling queue
//
// Purpose: owns the fetch PC, reads the combinational instruction memory and
// queues {pc, inst} pairs ahead of IF/ID; a taken redirect flushes the queue.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fetch_en                  allow new fetches (queue drains regardless)
//   imem_addr, imem_rdata     instruction memory word address / data
//   redirect_valid, redirect_pc  taken branch/jump from EX/MEM
//   out_valid, out_ready      head handshake towards decode
//   out_pc, out_inst          head entry (0 when empty)
//   count                     queue occupancy
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int                     XLEN     = cpu_pkg::XLEN,
  parameter  int                     DEPTH    = 4,
  parameter  int                     IMEM_AW  = 6,
  parameter  logic [XLEN-1:0]        RESET_PC = cpu_pkg::RESET_PC,
  localparam int                     CW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_inst,
  output logic [CW-1:0]      count
);

  logic [XLEN-1:0]   fetch_pc;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;
  logic [2*XLEN-1:0] head_data;

  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      // Wraps modulo 2^XLEN by construction of the width.
      fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  // Redirect doubles as the queue flush; a pop in that cycle is simply lost
  // with the rest of the entries, decode squashes it on its side.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({fetch_pc, imem_rdata}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign imem_addr           = fetch_pc[IMEM_AW+1:2];
  assign out_valid           = ~empty;
  assign {out_pc, out_inst}  = head_data;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end, directly upstream of the IF/ID register.
- Owns the fetch PC and addresses the combinational instruction memory.
- Buffers fetched {pc, inst} pairs in a small queue, so decode stalls back-pressure fetch instead of dropping instructions.
- Accepts a taken-branch redirect from EX/MEM, which flushes the queue and restarts fetch at the target.

Parameters:
- XLEN, 32, width of PC and instruction.
- DEPTH, 4, queue entries; power of two, at least 2.
- IMEM_AW, 6, instruction-memory word-address bits.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset.
- fetch_en  in  1  when 0, no new fetches; the queue still drains.
- imem_addr  out  IMEM_AW  word address to the instruction memory, equal to fetch_pc[IMEM_AW+1:2].
- imem_rdata  in  XLEN  instruction at imem_addr, valid in the same cycle (combinational memory).
- redirect_valid  in  1  taken branch or jump from EX/MEM.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_inst  out  XLEN  instruction of the head entry.
- count  out  $clog2(DEPTH+1)  queue occupancy.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC.
  - Queue empty; count = 0; out_valid = 0.
  - out_pc = 0; out_inst = 0.
  - imem_addr = RESET_PC[IMEM_AW+1:2].
- Reset mid-operation: rst discards all entries and any redirect or handshake in the same cycle.
- Pop: occurs when out_valid & out_ready.
- Push condition: fetch_en & !redirect_valid & (count < DEPTH | pop).
- Push action: {fetch_pc, imem_rdata} written at the tail, and fetch_pc <= fetch_pc + 4.
  - The addition is modulo 2^XLEN: 32'hFFFF_FFFC wraps to 0.
- No push: fetch_pc holds.
- Full: push and pop in the same cycle is legal; count is unchanged and ordering is preserved.
- Empty: out_valid = 0, and out_pc and out_inst are driven 0. out_ready is ignored.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no bypass.
- Redirect (highest priority after rst):
  - Queue cleared at the edge; count = 0 next cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; the low bits are ignored.
  - No push that cycle.
  - A pop handshake in the redirect cycle counts as completed. Decode squashes it via its own flush.
  - Target instruction pushed in cycle N+1 and presented in cycle N+2 (2-cycle redirect-to-valid).
- fetch_en = 0: the queue drains normally and fetch_pc holds. A redirect still updates fetch_pc.
- Outputs:
  - out_pc, out_inst and out_valid come from registered queue state plus a head pointer; no combinational path from out_ready.
  - count comes from registered queue state.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked separately, so full and empty are unambiguous.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN.
  - RESET_PC.
  - NOP_INST = 32'h0000_0013, used by the IF/ID flush logic, not by this block.
- One sub-module, fetch_fifo: synchronous FIFO (DEPTH x 2*XLEN) with push, pop, flush, count, and full/empty flags.
- fetch_queue adds the PC register, push gating and redirect logic.

Test Plan:
- Reset then stream: out_ready = 1, memory word i = 32'h1000_0000 + i.
  - Cycle 1 after reset: out_pc = 0, out_inst = 32'h1000_0000.
  - One entry per cycle after that, out_pc +4 each cycle.
  - count stays at or below 1.
- Backpressure: out_ready = 0 for 8 cycles.
  - count reaches 4 and holds; imem_addr freezes at 4.
  - out_pc stays 0.
  - Releasing out_ready yields PCs 0, 4, 8, 12, 16 with no gap.
- Redirect while full: redirect_valid = 1, redirect_pc = 32'h0000_0043.
  - Next cycle: count = 0, out_valid = 0, imem_addr = 16 (fetch_pc 0x40).
  - Cycle after: out_pc = 32'h0000_0040.
- Simultaneous push and pop when full: count stays 4 and the output order is strictly sequential.
- Reset mid-operation: rst = 1 while count = 3 and redirect_valid = 1.
  - Next cycle: count = 0, out_valid = 0, fetch_pc = RESET_PC.
- Wrap: redirect to 32'hFFFF_FFFC, then stream.
  - Output PCs are FFFF_FFFC, then 0000_0000, then 0000_0004.
